// File: rtl/mem_port_arbiter.sv
// Arbiter for the single-port data memory, shared by instruction fetch (reads only) and
// the MEM stage (reads and writes). MEM wins ties; a streak limit keeps fetch from starving.
module mem_port_arbiter #(
    parameter int AW             = 16,
    parameter int DW             = 16,
    parameter int MAX_MEM_STREAK = 4
) (
    input  logic          CLOCK_50,
    input  logic          RESET,

    input  logic          IF_REQ,
    input  logic [AW-1:0] IF_ADDR,
    output logic          IF_GNT,
    output logic          IF_STALL,
    output logic          IF_RVALID,
    output logic [DW-1:0] IF_RDATA,

    input  logic          MEM_REQ,
    input  logic          MEM_RW,
    input  logic [AW-1:0] MEM_ADDR,
    input  logic [DW-1:0] MEM_WDATA,
    output logic          MEM_GNT,
    output logic          MEM_STALL,
    output logic          MEM_RVALID,
    output logic [DW-1:0] MEM_RDATA,

    output logic          MEMINST,
    output logic          RW,
    output logic [AW-1:0] ADDR,
    output logic [DW-1:0] DATAIN,
    input  logic [DW-1:0] MEMDATAOUT
);

    localparam int SW = $clog2(MAX_MEM_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_MEM_STREAK);

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_IF   = 2'd1;
    localparam logic [1:0] R_MEM  = 2'd2;

    logic [1:0]    resp_state;
    logic [1:0]    resp_next;
    logic [SW-1:0] streak;
    logic [SW-1:0] streak_next;
    logic          if_win;
    logic          mem_win;

    // MEM is the older instruction, so it wins ties until it has held the port too long
    always_comb begin
        if_win  = 1'b0;
        mem_win = 1'b0;
        if (IF_REQ && MEM_REQ) begin
            if (streak == STREAK_MAX)
                if_win = 1'b1;
            else
                mem_win = 1'b1;
        end else if (IF_REQ) begin
            if_win = 1'b1;
        end else if (MEM_REQ) begin
            mem_win = 1'b1;
        end
    end

    always_comb begin
        resp_next = R_IDLE;
        if (if_win)
            resp_next = R_IF;
        else if (mem_win && !MEM_RW)
            resp_next = R_MEM;
    end

    always_comb begin
        streak_next = streak;
        if (!IF_REQ || if_win)
            streak_next = '0;
        else if (mem_win && streak != STREAK_MAX)
            streak_next = streak + 1'b1;
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            resp_state <= R_IDLE;
            streak     <= '0;
        end else begin
            resp_state <= resp_next;
            streak     <= streak_next;
        end
    end

    // Everything visible is held at zero while RESET is high, including a response in flight
    always_comb begin
        IF_GNT     = 1'b0;
        IF_STALL   = 1'b0;
        IF_RVALID  = 1'b0;
        IF_RDATA   = '0;
        MEM_GNT    = 1'b0;
        MEM_STALL  = 1'b0;
        MEM_RVALID = 1'b0;
        MEM_RDATA  = '0;
        MEMINST    = 1'b0;
        RW         = 1'b0;
        ADDR       = '0;
        DATAIN     = '0;
        if (!RESET) begin
            IF_GNT    = if_win;
            MEM_GNT   = mem_win;
            IF_STALL  = IF_REQ & ~if_win;
            MEM_STALL = MEM_REQ & ~mem_win;
            if (if_win) begin
                MEMINST = 1'b1;
                ADDR    = IF_ADDR;
            end else if (mem_win) begin
                MEMINST = 1'b1;
                RW      = MEM_RW;
                ADDR    = MEM_ADDR;
                DATAIN  = MEM_WDATA;
            end
            if (resp_state == R_IF) begin
                IF_RVALID = 1'b1;
                IF_RDATA  = MEMDATAOUT;
            end else if (resp_state == R_MEM) begin
                MEM_RVALID = 1'b1;
                MEM_RDATA  = MEMDATAOUT;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grants are checked each cycle, read responses are
// queued at grant time and matched by an independent monitor against a behavioural memory.
module tb_mem_port_arbiter;

    logic        CLOCK_50;
    logic        RESET;
    logic        IF_REQ;
    logic [15:0] IF_ADDR;
    logic        IF_GNT, IF_STALL, IF_RVALID;
    logic [15:0] IF_RDATA;
    logic        MEM_REQ, MEM_RW;
    logic [15:0] MEM_ADDR, MEM_WDATA;
    logic        MEM_GNT, MEM_STALL, MEM_RVALID;
    logic [15:0] MEM_RDATA;
    logic        MEMINST, RW;
    logic [15:0] ADDR, DATAIN;
    logic [15:0] MEMDATAOUT;

    int vectors = 0;
    int miscompares = 0;

    logic [16:0] expQ[$];
    logic [15:0] mem [0:65535];

    mem_port_arbiter #(.AW(16), .DW(16), .MAX_MEM_STREAK(4)) dut (
        .CLOCK_50(CLOCK_50), .RESET(RESET),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_GNT(IF_GNT), .IF_STALL(IF_STALL),
        .IF_RVALID(IF_RVALID), .IF_RDATA(IF_RDATA),
        .MEM_REQ(MEM_REQ), .MEM_RW(MEM_RW), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_GNT(MEM_GNT), .MEM_STALL(MEM_STALL), .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA),
        .MEMINST(MEMINST), .RW(RW), .ADDR(ADDR), .DATAIN(DATAIN), .MEMDATAOUT(MEMDATAOUT)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Synchronous single-port memory with one cycle of read latency
    always @(posedge CLOCK_50) begin
        if (MEMINST) begin
            if (RW)
                mem[ADDR] <= DATAIN;
            else
                MEMDATAOUT <= mem[ADDR];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; expResp: 0 none, 1 IF read response due, 2 MEM read response due
    task automatic applyStimulus(
        input logic rst, input logic ifReq, input logic [15:0] ifAddr,
        input logic memReq, input logic memRw, input logic [15:0] memAddr, input logic [15:0] memWdata,
        input logic expIfGnt, input logic expMemGnt, input int expResp, input logic [15:0] expData);
        logic [15:0] expAddr;
        @(posedge CLOCK_50);
        #1;
        RESET = rst; IF_REQ = ifReq; IF_ADDR = ifAddr;
        MEM_REQ = memReq; MEM_RW = memRw; MEM_ADDR = memAddr; MEM_WDATA = memWdata;
        @(negedge CLOCK_50);
        #1;
        expAddr = expIfGnt ? ifAddr : (expMemGnt ? memAddr : 16'h0);
        checkOutput("IF_GNT", IF_GNT, expIfGnt);
        checkOutput("MEM_GNT", MEM_GNT, expMemGnt);
        checkOutput("IF_STALL", IF_STALL, ifReq & ~expIfGnt & ~rst);
        checkOutput("MEM_STALL", MEM_STALL, memReq & ~expMemGnt & ~rst);
        checkOutput("MEMINST", MEMINST, expIfGnt | expMemGnt);
        checkOutput("RW", RW, expMemGnt & memRw);
        checkOutput("ADDR", ADDR, expAddr);
        if (!expIfGnt)
            checkOutput("DATAIN", DATAIN, expMemGnt ? memWdata : 16'h0);
        if (expResp == 1)
            expQ.push_back({1'b0, expData});
        else if (expResp == 2)
            expQ.push_back({1'b1, expData});
    endtask

    // Response monitor: every RVALID must match the oldest outstanding read
    always @(negedge CLOCK_50) begin
        logic [16:0] e;
        checkOutput("RVALID_ONEHOT", IF_RVALID & MEM_RVALID, 1'b0);
        if (!IF_RVALID)
            checkOutput("IF_RDATA_IDLE", IF_RDATA, 16'h0);
        if (!MEM_RVALID)
            checkOutput("MEM_RDATA_IDLE", MEM_RDATA, 16'h0);
        if (IF_RVALID || MEM_RVALID) begin
            if (expQ.size() == 0) begin
                checkOutput("UNEXPECTED_RVALID", {IF_RVALID, MEM_RVALID}, 2'b00);
            end else begin
                e = expQ.pop_front();
                checkOutput("RESP_PORT", MEM_RVALID, e[16]);
                checkOutput("RESP_DATA", e[16] ? MEM_RDATA : IF_RDATA, e[15:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        RESET = 1'b1; IF_REQ = 1'b0; IF_ADDR = '0;
        MEM_REQ = 1'b0; MEM_RW = 1'b0; MEM_ADDR = '0; MEM_WDATA = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
        mem[16'h0010] = 16'hBEEF;
        mem[16'h0020] = 16'h2020;
        mem[16'h0030] = 16'h3030;

        //            rst  ifReq ifAddr    memReq rw    memAddr   wdata     ifG   memG  resp data
        // reset with both requesting, then MEM wins the first free cycle
        applyStimulus(1'b1, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0200, 16'h0000, 1'b0, 1'b0, 0, 16'h0);
        applyStimulus(1'b0, 1'b1, 16'h0010, 1'b1, 1'b1, 16'h0300, 16'h1111, 1'b0, 1'b1, 0, 16'h0);
        // fetch alone
        applyStimulus(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1, 16'hBEEF);
        // write then read-after-write
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0200, 16'h1234, 1'b0, 1'b1, 0, 16'h0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0200, 16'h0000, 1'b0, 1'b1, 2, 16'h1234);
        // both held: MEM x4, forced IF slot, then MEM again
        for (int i = 0; i < 6; i++) begin
            if (i == 4)
                applyStimulus(1'b0, 1'b1, 16'h0020, 1'b1, 1'b0, 16'h0300, 16'h0, 1'b1, 1'b0, 1, 16'h2020);
            else
                applyStimulus(1'b0, 1'b1, 16'h0020, 1'b1, 1'b0, 16'h0300, 16'h0, 1'b0, 1'b1, 2, 16'h1111);
        end
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 0, 16'h0);
        // alternating reads, back to back
        applyStimulus(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1, 16'hBEEF);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b1, 2, 16'h2020);
        applyStimulus(1'b0, 1'b1, 16'h0030, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1, 16'h3030);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, 2, 16'hBEEF);
        // fetch granted, then reset drops its response; fetch regranted afterwards
        applyStimulus(1'b0, 1'b1, 16'h0030, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 0, 16'h0);
        applyStimulus(1'b1, 1'b1, 16'h0030, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 0, 16'h0);
        applyStimulus(1'b0, 1'b1, 16'h0030, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1, 16'h3030);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 0, 16'h0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 0, 16'h0);

        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        #1;
        checkOutput("RESP_QUEUE_EMPTY", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
